// File: rtl/conv1_pkg.sv
// Shared conv1 constants and loader state encoding; the weight read addresser
// imports the same constants so both ends agree on the memory layout.
package conv1_pkg;

  localparam int DATA_W = 8;
  localparam int KSIZE  = 25;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = $clog2(KSIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/conv1_k_mem_write.sv
// Conv1 kernel weight loader: one beat carries a kernel 0 and a kernel 1 weight,
// written in the same cycle to addr i and KSIZE+i; done releases the datapath.
module conv1_k_mem_write
  import conv1_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2*DATA_W-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     waddr0,
  output logic [ADDR_W-1:0]     waddr1,
  output logic [DATA_W-1:0]     wdata0,
  output logic [DATA_W-1:0]     wdata1,
  output logic                  we,
  output logic                  busy,
  output logic                  done
);

  ld_state_e          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               accept_s;

  // in_ready is a register tracking state==LOAD, so acceptance never depends
  // combinationally on in_valid feeding back into in_ready.
  assign accept_s = in_valid && in_ready;

  // Loader FSM, beat counter and registered write stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      in_ready <= 1'b0;
      waddr0   <= '0;
      waddr1   <= ADDR_W'(KSIZE);
      wdata0   <= '0;
      wdata1   <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= LOAD;
            cnt_r    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            we     <= 1'b1;
            waddr0 <= ADDR_W'(cnt_r);
            waddr1 <= ADDR_W'(KSIZE) + ADDR_W'(cnt_r);
            wdata0 <= in_data[DATA_W-1:0];
            wdata1 <= in_data[2*DATA_W-1:DATA_W];
            // Counter stops at KSIZE-1 instead of wrapping.
            if (cnt_r == CNT_W'(KSIZE - 1)) begin
              state_r  <= FLUSH;
              in_ready <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          state_r <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          if (start) begin
            state_r  <= LOAD;
            cnt_r    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_k_mem_write.sv
// Scoreboard bench for conv1_k_mem_write: the driver queues the expected write
// for each accepted beat, the monitor pops and compares on every we.
module tb_conv1_k_mem_write;
  import conv1_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } wr_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [2*DATA_W-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ADDR_W-1:0]   waddr0, waddr1;
  logic [DATA_W-1:0]   wdata0, wdata1;
  logic                we, busy, done;

  int  checks = 0;
  int  errors = 0;
  int  wcount = 0;
  int  exp_idx = 0;
  wr_t sb[$];

  conv1_k_mem_write dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest queued beat.
  always @(posedge clk) begin
    #1;
    if (reset_n && we) begin
      wcount++;
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("waddr0", 32'(waddr0), 32'(e.a0));
        chk("waddr1", 32'(waddr1), 32'(e.a1));
        chk("wdata0", 32'(wdata0), 32'(e.d0));
        chk("wdata1", 32'(wdata1), 32'(e.d1));
      end
    end
  end

  // Offer one beat {100+idx, idx}; wait (bounded) for in_ready and queue the write.
  task automatic beat();
    int n = 0;
    logic [DATA_W-1:0] k0, k1;
    k0 = DATA_W'(exp_idx);
    k1 = DATA_W'(100 + exp_idx);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {k1, k0};
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{a0: ADDR_W'(exp_idx), a1: ADDR_W'(KSIZE + exp_idx), d0: k0, d1: k1});
      exp_idx++;
    end
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Last accepted beat: FLUSH cycle shows final write, done rises one cycle later.
  task automatic end_of_load();
    gap();
    chk("flush_we", 32'(we), 32'd1);
    chk("flush_waddr1", 32'(waddr1), 32'd49);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("done_set", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_we", 32'(we), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("we_count", 32'(wcount), 32'(KSIZE));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_waddr0"}, 32'(waddr0), 32'd0);
    chk({tag, "_waddr1"}, 32'(waddr1), 32'd25);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state, then valid ignored in IDLE.
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_we", 32'(we), 32'd0);
    end

    // 2. Full load, continuous valid.
    wcount = 0; exp_idx = 0;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < KSIZE; i++) beat();
    end_of_load();

    // 4. Valid in DONE is ignored, done holds.
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("done_ready", 32'(in_ready), 32'd0);
    end

    // 5b/3. Restart from DONE, then load with a gap after every beat.
    wcount = 0; exp_idx = 0;
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < KSIZE - 1; i++) begin
      beat();
      gap();
    end
    beat();
    end_of_load();

    // 5a. Start in LOAD after 10 beats is ignored.
    wcount = 0; exp_idx = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) beat();
    pulse_start();
    chk("load_start_busy", 32'(busy), 32'd1);
    for (int i = 10; i < KSIZE; i++) beat();
    end_of_load();

    // 6. Asynchronous reset after 12 beats, then full reload.
    wcount = 0; exp_idx = 0;
    pulse_start();
    for (int i = 0; i < 12; i++) beat();
    gap();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    wcount = 0; exp_idx = 0;
    pulse_start();
    for (int i = 0; i < KSIZE - 1; i++) beat();
    chk("pre_done", 32'(done), 32'd0);
    beat();
    end_of_load();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
